// File: rtl/bsg_dmc_clock_monitor_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bsg_dmc_clock_monitor_scheduler
// Brief    : Round-robin scheduler that time-shares one clock-measurement
//            counter across num_clks_p clocks and bound-checks each count.
//            Define BSG_DMC_CLK_MON_STICKY_EN for sticky mismatch flags.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_dmc_clock_monitor_scheduler #(
  parameter int num_clks_p     = 4,
  parameter int count_width_p  = 16,
  parameter int window_width_p = 16,
  parameter int clear_cycles_p = 4,
  parameter int sync_cycles_p  = 4
) (
  input  logic                                                clk_i,
  input  logic                                                reset_n_i,
  input  logic                                                en_i,
  input  logic [window_width_p-1:0]                           window_i,
  input  logic [num_clks_p*count_width_p-1:0]                 lo_bound_i,
  input  logic [num_clks_p*count_width_p-1:0]                 hi_bound_i,
  input  logic [count_width_p-1:0]                            count_i,
  input  logic                                                clr_mismatch_i,
  output logic [((num_clks_p > 1) ? $clog2(num_clks_p) : 1)-1:0] sel_o,
  output logic                                                clear_o,
  output logic                                                count_en_o,
  output logic                                                sample_v_o,
  output logic [((num_clks_p > 1) ? $clog2(num_clks_p) : 1)-1:0] sample_id_o,
  output logic [count_width_p-1:0]                            sample_count_o,
  output logic [num_clks_p-1:0]                               mismatch_o,
  output logic                                                sweep_done_o
);

  localparam int c_sel_w = (num_clks_p > 1) ? $clog2(num_clks_p) : 1;
  localparam int c_clr_w = $clog2(clear_cycles_p + 1);
  localparam int c_syn_w = $clog2(sync_cycles_p + 1);
  localparam int c_cnt_a = (window_width_p > c_clr_w) ? window_width_p : c_clr_w;
  localparam int c_cnt_w = (c_cnt_a > c_syn_w) ? c_cnt_a : c_syn_w;

  localparam logic [c_cnt_w-1:0] c_clr_last = c_cnt_w'(clear_cycles_p - 1);
  localparam logic [c_cnt_w-1:0] c_syn_last = c_cnt_w'(sync_cycles_p - 1);
  localparam logic [c_sel_w-1:0] c_sel_last = c_sel_w'(num_clks_p - 1);

  typedef enum logic [2:0] {
    e_idle   = 3'd0,
    e_clear  = 3'd1,
    e_window = 3'd2,
    e_settle = 3'd3,
    e_sample = 3'd4
  } state_e;

  state_e                    r_state;
  state_e                    w_state_next;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [window_width_p-1:0] r_win;
  logic [c_cnt_w-1:0]        w_win_last;
  logic [c_sel_w-1:0]        r_sel;
  logic                      r_clear;
  logic                      r_count_en;
  logic                      r_sample_v;
  logic                      r_sweep_done;
  logic [num_clks_p-1:0]     r_mismatch;
  logic [num_clks_p-1:0]     w_mismatch_next;
  logic [num_clks_p-1:0]     w_fail;
  logic [num_clks_p-1:0]     w_hit;
  logic [num_clks_p-1:0]     w_mismatch_base;
  logic                      w_sampling;

  assign w_win_last = c_cnt_w'(r_win) - c_cnt_w'(1);
  assign w_sampling = (r_state == e_sample);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= e_idle;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      e_idle:   if (en_i)                 w_state_next = e_clear;
      e_clear:  if (r_cnt == c_clr_last)  w_state_next = e_window;
      e_window: if (r_cnt == w_win_last)  w_state_next = e_settle;
      e_settle: if (r_cnt == c_syn_last)  w_state_next = e_sample;
      e_sample: w_state_next = en_i ? e_clear : e_idle;
      default:  w_state_next = e_idle;
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt        <= '0;
      r_win        <= window_width_p'(1);
      r_sel        <= '0;
      r_clear      <= 1'b0;
      r_count_en   <= 1'b0;
      r_sample_v   <= 1'b0;
      r_sweep_done <= 1'b0;
      r_mismatch   <= '0;
    end else begin
      if ((w_state_next != r_state) || (r_state == e_idle)) r_cnt <= '0;
      else                                                  r_cnt <= r_cnt + c_cnt_w'(1);
      if ((w_state_next == e_clear) && (r_state != e_clear))
        r_win <= (window_i == '0) ? window_width_p'(1) : window_i;
      if (w_sampling)
        r_sel <= (r_sel == c_sel_last) ? '0 : r_sel + c_sel_w'(1);
      r_clear      <= (w_state_next == e_clear);
      r_count_en   <= (w_state_next == e_window);
      r_sample_v   <= (w_state_next == e_sample);
      r_sweep_done <= (w_state_next == e_sample) && (r_sel == c_sel_last);
      r_mismatch   <= w_mismatch_next;
    end
  end

  for (genvar k = 0; k < num_clks_p; k++) begin : g_chan
    logic [count_width_p-1:0] w_lo;
    logic [count_width_p-1:0] w_hi;
    assign w_lo      = lo_bound_i[k*count_width_p +: count_width_p];
    assign w_hi      = hi_bound_i[k*count_width_p +: count_width_p];
    assign w_hit[k]  = w_sampling && (r_sel == c_sel_w'(k));
    assign w_fail[k] = w_hit[k] && ((count_i < w_lo) || (count_i > w_hi));
  end

  // A failing sample always wins over a simultaneous clear.
  assign w_mismatch_base = clr_mismatch_i ? '0 : r_mismatch;
`ifdef BSG_DMC_CLK_MON_STICKY_EN
  assign w_mismatch_next = w_mismatch_base | w_fail;
`else
  assign w_mismatch_next = (w_mismatch_base & ~w_hit) | w_fail;
`endif

  assign sel_o          = r_sel;
  assign sample_id_o    = r_sel;
  assign clear_o        = r_clear;
  assign count_en_o     = r_count_en;
  assign sample_v_o     = r_sample_v;
  assign sweep_done_o   = r_sweep_done;
  assign mismatch_o     = r_mismatch;
  assign sample_count_o = r_sample_v ? count_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_bsg_dmc_clock_monitor_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_dmc_clock_monitor_scheduler
// Brief    : Randomized self-checking bench with a channel-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_dmc_clock_monitor_scheduler;
  localparam int N   = 4;
  localparam int CW  = 16;
  localparam int WW  = 16;
  localparam int CLR = 4;
  localparam int SYN = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            en;
  logic [WW-1:0]   window;
  logic [N*CW-1:0] lo_bound;
  logic [N*CW-1:0] hi_bound;
  logic [CW-1:0]   count;
  logic            clr;
  logic [1:0]      sel;
  logic            clear;
  logic            count_en;
  logic            sample_v;
  logic [1:0]      sample_id;
  logic [CW-1:0]   sample_count;
  logic [N-1:0]    mismatch;
  logic            sweep_done;

  logic [CW-1:0] cnt_tab [N];
  logic [CW-1:0] lo_tab  [N];
  logic [CW-1:0] hi_tab  [N];

  int           tests = 0;
  int           fails = 0;
  int           exp_ch = 0;
  logic [N-1:0] exp_mis = '0;
  int           carry_clr = 0;
  int           carry_en = 0;

  always #5 clk = ~clk;

  always_comb begin
    lo_bound = '0;
    hi_bound = '0;
    for (int k = 0; k < N; k++) begin
      lo_bound[k*CW +: CW] = lo_tab[k];
      hi_bound[k*CW +: CW] = hi_tab[k];
    end
  end
  // The measured clock's count is whatever the selected channel presents.
  assign count = cnt_tab[sel];

  bsg_dmc_clock_monitor_scheduler #(
    .num_clks_p(N), .count_width_p(CW), .window_width_p(WW),
    .clear_cycles_p(CLR), .sync_cycles_p(SYN)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .window_i(window),
    .lo_bound_i(lo_bound), .hi_bound_i(hi_bound), .count_i(count),
    .clr_mismatch_i(clr), .sel_o(sel), .clear_o(clear), .count_en_o(count_en),
    .sample_v_o(sample_v), .sample_id_o(sample_id), .sample_count_o(sample_count),
    .mismatch_o(mismatch), .sweep_done_o(sweep_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_ch = 0;
    exp_mis = '0;
    carry_clr = 0;
    carry_en = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    tests++;
    if ({clear, count_en, sample_v, sweep_done, sel, sample_id, sample_count, mismatch} !== '0) begin
      fails++;
      $display("FAIL reset_values: got clr=%b en=%b sv=%b sd=%b sel=%0d id=%0d cnt=%0d mis=%b, want all 0",
               clear, count_en, sample_v, sweep_done, sel, sample_id, sample_count, mismatch);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    int strobes = 0;
    int bad_sel = 0;
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      strobes += int'(clear) + int'(count_en) + int'(sample_v) + int'(sweep_done);
      if (sel !== 2'd0) bad_sel++;
    end
    tests++;
    if (strobes != 0) begin
      fails++;
      $display("FAIL idle_strobes: got %0d strobe cycles, want 0", strobes);
    end
    tests++;
    if (bad_sel != 0) begin
      fails++;
      $display("FAIL idle_sel: got %0d cycles with sel!=0, want 0", bad_sel);
    end
  endtask

  task automatic test_timing();
    int first_clr = -1;
    int s1 = -1;
    int s2 = -1;
    for (int k = 0; k < N; k++) begin
      lo_tab[k] = 16'd38; hi_tab[k] = 16'd42; cnt_tab[k] = 16'd40;
    end
    window = 16'd20;
    en = 1'b1;
    for (int i = 1; i <= 100 && s2 < 0; i++) begin
      step();
      if (clear && first_clr < 0) first_clr = i;
      if (sample_v) begin
        if (s1 < 0) s1 = i;
        else        s2 = i;
      end
    end
    tests++;
    if (first_clr != 1) begin
      fails++;
      $display("FAIL clear_latency: got cycle %0d, want 1", first_clr);
    end
    tests++;
    if (s1 != CLR + 20 + SYN + 1) begin
      fails++;
      $display("FAIL first_sample: got cycle %0d, want %0d", s1, CLR + 20 + SYN + 1);
    end
    tests++;
    if (s2 - s1 != CLR + 20 + SYN + 1) begin
      fails++;
      $display("FAIL channel_period: got %0d, want %0d", s2 - s1, CLR + 20 + SYN + 1);
    end
  endtask

  task automatic test_reset_mid_window();
    bit seen = 0;
    int samples = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (count_en) seen = 1;
    end
    repeat (3) step();
    #3 reset_n = 1'b0;
    #1;
    tests++;
    if (!seen || {clear, count_en, sample_v, sweep_done, sel, sample_id, sample_count, mismatch} !== '0) begin
      fails++;
      $display("FAIL async_reset: window_seen=%0d clr=%b en=%b sv=%b sel=%0d id=%0d cnt=%0d mis=%b, want all 0",
               seen, clear, count_en, sample_v, sel, sample_id, sample_count, mismatch);
    end
    en = 1'b0;
    step();
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      samples += int'(sample_v);
    end
    tests++;
    if (samples != 0) begin
      fails++;
      $display("FAIL aborted_window: got %0d samples, want 0", samples);
    end
  endtask

  // Runs n channel measurements against the model. clr_ch pulses clr on that
  // channel's sample; en drops during stop_ch's window.
  task automatic test_sweep(input int n, input int clr_ch, input int stop_ch);
    bit   seen;
    int   n_clr;
    int   n_en;
    int   weff;
    logic fail;
    for (int s = 0; s < n; s++) begin
      seen  = 0;
      n_clr = carry_clr;
      n_en  = carry_en;
      weff  = (window == '0) ? 1 : int'(window);
      for (int i = 0; i < 300 && !seen; i++) begin
        step();
        if (sample_v) seen = 1;
        else begin
          n_clr += int'(clear);
          n_en  += int'(count_en);
          if (exp_ch == stop_ch && count_en) en = 1'b0;
        end
      end
      tests++;
      if (!seen) begin
        fails++;
        $display("FAIL sample_timeout: channel %0d produced no sample", exp_ch);
        return;
      end
      tests++;
      if (sample_id !== 2'(exp_ch) || sel !== 2'(exp_ch)) begin
        fails++;
        $display("FAIL sample_id: got id=%0d sel=%0d, want %0d", sample_id, sel, exp_ch);
      end
      tests++;
      if (sample_count !== cnt_tab[exp_ch]) begin
        fails++;
        $display("FAIL sample_count: ch %0d got %0d, want %0d", exp_ch, sample_count, cnt_tab[exp_ch]);
      end
      tests++;
      if (sweep_done !== (exp_ch == N - 1)) begin
        fails++;
        $display("FAIL sweep_done: ch %0d got %b, want %b", exp_ch, sweep_done, exp_ch == N - 1);
      end
      tests++;
      if (n_clr != CLR || n_en != weff) begin
        fails++;
        $display("FAIL phase_lengths: ch %0d got clear=%0d en=%0d, want clear=%0d en=%0d",
                 exp_ch, n_clr, n_en, CLR, weff);
      end
      fail = (cnt_tab[exp_ch] < lo_tab[exp_ch]) || (cnt_tab[exp_ch] > hi_tab[exp_ch]);
      if (clr_ch == exp_ch) begin
        clr = 1'b1;
        exp_mis = '0;
      end
`ifdef BSG_DMC_CLK_MON_STICKY_EN
      if (fail) exp_mis[exp_ch] = 1'b1;
`else
      exp_mis[exp_ch] = fail;
`endif
      exp_ch = (exp_ch + 1) % N;
      step();
      clr = 1'b0;
      tests++;
      if (mismatch !== exp_mis) begin
        fails++;
        $display("FAIL mismatch: got %b, want %b", mismatch, exp_mis);
      end
      carry_clr = int'(clear);
      carry_en  = int'(count_en);
    end
  endtask

  task automatic test_random_sweeps();
    int lo;
    int hi;
    for (int k = 0; k < N; k++) begin
      lo = $urandom_range(30, 10);
      hi = lo + $urandom_range(10, 0) - 3;
      lo_tab[k]  = CW'(lo);
      hi_tab[k]  = CW'(hi);
      cnt_tab[k] = CW'($urandom_range(hi + 5, lo - 5));
    end
    window = WW'($urandom_range(6, 0));
    en = 1'b1;
    test_sweep(8, -1, -1);
  endtask

  task automatic test_graceful_stop();
    int strobes = 0;
    int bad_sel = 0;
    test_sweep(2, -1, 1);
    for (int i = 0; i < 40; i++) begin
      step();
      strobes += int'(clear) + int'(count_en) + int'(sample_v);
      if (sel !== 2'd2) bad_sel++;
    end
    tests++;
    if (strobes != 0 || bad_sel != 0) begin
      fails++;
      $display("FAIL graceful_stop: got %0d strobes, %0d cycles sel!=2 (sel=%0d), want 0/0", strobes, bad_sel, sel);
    end
    en = 1'b1;
    test_sweep(1, -1, 2);
  endtask

  task automatic test_boundary();
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_mis = '0;
    tests++;
    if (mismatch !== '0) begin
      fails++;
      $display("FAIL clr_mismatch: got %b, want 0000", mismatch);
    end
    for (int k = 0; k < N; k++) begin
      lo_tab[k] = 16'd38; hi_tab[k] = 16'd42;
    end
    cnt_tab[0] = 16'd38;
    cnt_tab[1] = 16'd42;
    cnt_tab[2] = 16'd37;
    cnt_tab[3] = 16'd43;
    window = '0;
    en = 1'b1;
    test_sweep(4, -1, -1);
    tests++;
    if (mismatch !== 4'b1100) begin
      fail_line: begin
        fails++;
        $display("FAIL boundary_bits: got %b, want 1100", mismatch);
      end
    end
  endtask

  task automatic test_sticky();
    int   c;
    logic want;
    c = exp_ch;
    for (int k = 0; k < N; k++) cnt_tab[k] = 16'd40;
    cnt_tab[c] = 16'd50;
    test_sweep(1, -1, -1);
    cnt_tab[c] = 16'd40;
    test_sweep(N, -1, -1);
`ifdef BSG_DMC_CLK_MON_STICKY_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    tests++;
    if (mismatch[c] !== want) begin
      fails++;
      $display("FAIL fail_then_pass: ch %0d got %b, want %b", c, mismatch[c], want);
    end
    cnt_tab[(c + 1) % N] = 16'd50;
    cnt_tab[(c + 2) % N] = 16'd50;
    test_sweep(1, -1, -1);
    test_sweep(1, (c + 2) % N, (c + 2) % N);
    tests++;
    if (mismatch !== N'(1 << ((c + 2) % N))) begin
      fails++;
      $display("FAIL clear_with_fail: got %b, want %b", mismatch, N'(1 << ((c + 2) % N)));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    window  = 16'd1;
    for (int k = 0; k < N; k++) begin
      lo_tab[k] = '0; hi_tab[k] = '1; cnt_tab[k] = '0;
    end
    test_reset();
    test_idle();
    test_timing();
    test_reset_mid_window();
    test_random_sweeps();
    test_graceful_stop();
    test_boundary();
    test_sticky();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bsg_dmc_clock_monitor_scheduler.md
# bsg_dmc_clock_monitor_scheduler

Synthesizable controller that time-shares one DDR-clock measurement counter (async gray counter in the measured domain, synchronized and gray-to-binary converted into this domain) among `num_clks_p` monitored clocks. It round-robins through the channels. For each channel it clears the counter, gates counting for a programmable window of local clock cycles, waits for the synchronizer to settle, samples the count and checks it against per-channel inclusive bounds. It sits in the DMC clock/test infrastructure and drives the clock-select mux in front of the shared counter.

## Interface
- `num_clks_p`, 4: number of monitored clocks; must be ≥1.
- `count_width_p`, 16: width of the measured count and the bounds.
- `window_width_p`, 16: width of the window length input.
- `clear_cycles_p`, 4: cycles `clear_o` is held per channel; must be ≥1.
- `sync_cycles_p`, 4: settle cycles between window end and sample; must be ≥1.
- `clk_i` in, 1: local (FPGA/system) clock; only clock of the block.
- `reset_n_i` in, 1: asynchronous, active-low reset.
- `en_i` in, 1: run sweeps while high.
- `window_i` in, `window_width_p`: window length in `clk_i` cycles; latched on entry to CLEAR.
- `lo_bound_i` in, `num_clks_p*count_width_p`: per-channel inclusive lower bound; channel k at slice k.
- `hi_bound_i` in, `num_clks_p*count_width_p`: per-channel inclusive upper bound.
- `count_i` in, `count_width_p`: synchronized binary count from the shared counter.
- `clr_mismatch_i` in, 1: clear all mismatch bits.
- `sel_o` out, `max(1,$clog2(num_clks_p))`: selected channel.
- `clear_o` out, 1: counter clear.
- `count_en_o` out, 1: counter increment enable.
- `sample_v_o` out, 1: one-cycle strobe; `count_i` is sampled this cycle.
- `sample_id_o` out, `max(1,$clog2(num_clks_p))`: channel of the current sample; equals `sel_o`.
- `sample_count_o` out, `count_width_p`: `count_i` passed through during `sample_v_o`, otherwise 0.
- `mismatch_o` out, `num_clks_p`: per-channel failure flags.
- `sweep_done_o` out, 1: one-cycle pulse on the last channel's sample.

## Operation
- States: IDLE, CLEAR, WINDOW, SETTLE, SAMPLE.
- IDLE: all strobes low. When `en_i` = 1, go to CLEAR with the current `sel_o`. The first sweep after reset starts at channel 0.
- CLEAR:
  - `clear_o` = 1 for exactly `clear_cycles_p` cycles.
  - `window_i` is latched on entry. A latched value of 0 is treated as 1.
  - Then go to WINDOW.
- WINDOW: `count_en_o` = 1 for exactly W latched cycles, then go to SETTLE.
- SETTLE: wait `sync_cycles_p` cycles with `clear_o` and `count_en_o` low, then go to SAMPLE.
- SAMPLE (1 cycle):
  - Assert `sample_v_o`.
  - Compute fail = (`count_i` < lo[sel]) or (`count_i` > hi[sel]).
  - The mismatch bit updates at the closing edge.
  - If `sel_o` = `num_clks_p`-1, pulse `sweep_done_o`.
  - Advance `sel_o` (wrap to 0).
  - If `en_i` = 1, go to CLEAR; otherwise go to IDLE.
- `en_i` falling mid-channel: the current channel completes through SAMPLE, then the block goes to IDLE. No truncated windows.
- `sel_o` changes only on the SAMPLE→next edge, so it is stable from CLEAR through SAMPLE.
- `clr_mismatch_i` coinciding with a failing SAMPLE: the set wins for that channel; the other channels clear.
- Bounds are unsigned. If lo > hi, every sample fails.

## Timing
- Reset (async, immediate) values:
  - State IDLE.
  - `sel_o` = 0, `sample_id_o` = 0.
  - `clear_o`, `count_en_o`, `sample_v_o`, `sweep_done_o` = 0.
  - `sample_count_o` = 0.
  - `mismatch_o` = 0.
- Reset mid-window aborts the window; no sample is produced.
- `en_i` high in cycle t (IDLE) gives `clear_o` high in cycles t+1 … t+`clear_cycles_p`.
- Per-channel period = `clear_cycles_p` + W + `sync_cycles_p` + 1 cycles.
- `mismatch_o` reflects a sample from the cycle after `sample_v_o`.
- All outputs are registered except `sample_count_o`, which passes `count_i` through during `sample_v_o`.

## Configuration
- `BSG_DMC_CLK_MON_STICKY_EN` defined:
  - A failing sample sets that channel's bit.
  - Passing samples leave the bit unchanged.
  - Only reset or `clr_mismatch_i` clears it.
- Not defined:
  - Each SAMPLE overwrites that channel's bit with fail (1) or pass (0).
  - `clr_mismatch_i` still clears all bits.

## Test plan
- Reset/idle:
  - Assert `reset_n_i` = 0 mid-WINDOW → all outputs reach reset values without a clock edge.
  - Hold `en_i` = 0 for 50 cycles → no strobes, `sel_o` = 0.
- Single-channel pass, `num_clks_p` = 1:
  - Setup: W = 20, bounds [38,42], `count_i` = 40 at SAMPLE.
  - Expect `sample_v_o` 29 cycles after CLEAR entry (4+20+4+1), `mismatch_o` = 0, `sweep_done_o` every 29 cycles.
- Four-channel sweep:
  - Setup: channel 2 `count_i` = 50 with bounds [38,42].
  - Expect `sel_o` order 0,1,2,3,0, `sample_id_o` = 2 on the failing strobe, `mismatch_o` = 4'b0100, `sweep_done_o` only on channel 3.
- Boundary values:
  - `count_i` = lo and `count_i` = hi → pass; lo-1 and hi+1 → fail.
  - `window_i` = 0 → `count_en_o` high exactly 1 cycle.
- Graceful stop:
  - Drop `en_i` during channel 1's WINDOW → channel 1 still samples, then IDLE with `sel_o` = 2; raising `en_i` resumes at channel 2.
- Sticky vs non-sticky:
  - Stimulus on one channel: fail, then pass; separately, `clr_mismatch_i` on the same cycle as a fail.
  - With macro: bit stays 1 after the pass.
  - Without macro: bit returns to 0 after the pass.
  - Both builds: simultaneous clear+fail leaves the bit at 1.
